ntt_axil_host: RTL and testbench
================================

NTT_AXIL_HOST -- requirements
Module: ntt_axil_host

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, base of the accelerator register window.
REQ-004 SHALL have parameter POLL_LIMIT, default 16'hFFFF, max status reads before timeout.
REQ-005 SHALL have ports: ACLK in 1 clock; ARESETN in 1 reset, asynchronous, active-low; all logic on rising ACLK.
REQ-006 SHALL have AXI4-Lite master write ports: M_AWADDR out C_ADDR_WIDTH; M_AWVALID out 1; M_AWREADY in 1; M_WDATA out 32; M_WSTRB out 4; M_WVALID out 1; M_WREADY in 1; M_BRESP in 2; M_BVALID in 1; M_BREADY out 1.
REQ-007 SHALL have AXI4-Lite master read ports: M_ARADDR out C_ADDR_WIDTH; M_ARVALID out 1; M_ARREADY in 1; M_RDATA in 32; M_RRESP in 2; M_RVALID in 1; M_RREADY out 1.
REQ-008 SHALL have user ports: start in 1 (request run); p_in in 32 (modulus); r_in in 32 (root); busy out 1; done out 1 (one-cycle pulse); error out 1; timeout out 1; status out 32 (last status word read).

Function
REQ-009 SHALL execute, on start while idle, the sequence: write p_in to BASE+0x08, write r_in to BASE+0x0C, write 0x3 to BASE+0x04 (run + complete-valid), poll BASE+0x00 until bit0=1, write 0x0 to BASE+0x04, then pulse done.
REQ-010 SHALL capture p_in and r_in on the accepting start cycle; later changes have no effect.
REQ-011 SHALL ignore start while busy=1.
REQ-012 SHALL use top states IDLE, WR_P, WR_R, WR_RUN, POLL, WR_CLR, FINISH; busy=1 in every state except IDLE.
REQ-013 SHALL drive each write with AWVALID and WVALID asserted in the same cycle, each held until its own handshake, each dropped independently the cycle after its handshake; the responder may accept AW and W in different cycles.
REQ-014 SHALL assert M_BREADY only after both AW and W handshakes and hold it until BVALID.
REQ-015 SHALL drive M_WSTRB=4'hF on all writes; M_AWADDR/M_WDATA stable while the corresponding VALID is high.
REQ-016 SHALL drive a read with ARVALID held to handshake, then RREADY=1 until RVALID; status <= M_RDATA on the R handshake.
REQ-017 SHALL re-issue the status read the cycle after an R handshake with bit0=0; issue at most one outstanding transaction at any time.
REQ-018 SHALL count status reads in a 16-bit counter cleared on start; when POLL_LIMIT reads completed without bit0=1, SHALL set timeout=1, error=1 and go to WR_CLR.
REQ-019 SHALL on any BRESP!=0 or RRESP!=0 set error=1 and go to WR_CLR; an error response in WR_CLR itself goes to FINISH.
REQ-020 SHALL in FINISH pulse done for exactly one cycle and return to IDLE; error/timeout/status hold until the next accepted start, which clears error and timeout.
REQ-021 SHALL accept VALID/READY arriving in the same cycle as VALID assertion (zero-wait responder) and arbitrary wait states.

Reset
REQ-022 SHALL on ARESETN low asynchronously force IDLE, all VALID/READY outputs 0, busy=0, done=0, error=0, timeout=0, status=0, poll counter=0.
REQ-023 SHALL on reset mid-transaction abandon it without completion; no done pulse after reset release.
REQ-024 SHALL leave M_AWADDR, M_WDATA, M_ARADDR don't-care while their VALID is 0.

Structure
REQ-025 SHALL place register offsets (0x00, 0x04, 0x08, 0x0C), control bit positions (run=0, complete-valid=1, complete=0 of status), top state encoding and OKAY response code in package ntt_axil_pkg.
REQ-026 SHALL implement AXI handshaking in one sub-module ntt_axil_xact (single write-or-read transaction engine: req, we, addr, wdata -> ack, rdata, resp), instantiated once and sequenced by the top FSM.

Verification
REQ-027 Zero-wait responder, start with p_in=0x3001, r_in=0x11, complete after 3 polls -> writes 0x08=0x3001, 0x0C=0x11, 0x04=0x3, four reads of 0x00, write 0x04=0x0, done one cycle, error=0, status bit0=1.
REQ-028 Responder accepting AW 2 cycles before W and delaying BVALID 3 cycles -> AWVALID drops after its handshake, WVALID held until WREADY, BREADY held until BVALID, same write data.
REQ-029 POLL_LIMIT=4, complete never set -> exactly 4 status reads, write 0x04=0x0, done, error=1, timeout=1.
REQ-030 BRESP=2'b10 on the write to 0x0C -> no run write, write 0x04=0x0, done, error=1, timeout=0.
REQ-031 ARESETN low during POLL with ARVALID high -> ARVALID=0, busy=0 immediately; no done after release; new start runs full sequence.
REQ-032 start pulsed again while busy with p_in=0xFFFF -> ignored; written p remains the originally captured value.

Source files
------------

// File: rtl/ntt_axil_pkg.sv
// ntt_axil_pkg: register map, control bits, FSM encoding and response codes for the NTT AXI-Lite host.
package ntt_axil_pkg;
   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_CTRL = 8'h04;
   localparam logic [7:0] OFF_P = 8'h08;
   localparam logic [7:0] OFF_R = 8'h0C;
   localparam int CTRL_RUN = 0;
   localparam int CTRL_CV = 1;
   localparam int STAT_CPL = 0;
   localparam logic [31:0] CTRL_GO = (32'd1 << CTRL_RUN) | (32'd1 << CTRL_CV);
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [3:0] WSTRB_ALL = 4'hF;
   typedef logic [2:0] state_t;
   localparam state_t IDLE = 3'd0;
   localparam state_t WR_P = 3'd1;
   localparam state_t WR_R = 3'd2;
   localparam state_t WR_RUN = 3'd3;
   localparam state_t POLL = 3'd4;
   localparam state_t WR_CLR = 3'd5;
   localparam state_t FINISH = 3'd6;
   function automatic logic is_xact(state_t s);
      return s inside {WR_P, WR_R, WR_RUN, POLL, WR_CLR};
   endfunction
   function automatic logic [7:0] reg_off(state_t s);
      return s == WR_P ? OFF_P : s == WR_R ? OFF_R : s == POLL ? OFF_STATUS : OFF_CTRL;
   endfunction
endpackage

// File: rtl/ntt_axil_if.sv
// ntt_axil_if: AXI4-Lite bus between the NTT host (master) and the accelerator register window (slave).
interface ntt_axil_if #(parameter int C_ADDR_WIDTH = 32);
   logic [C_ADDR_WIDTH-1:0] M_AWADDR;
   logic M_AWVALID, M_AWREADY;
   logic [31:0] M_WDATA;
   logic [3:0] M_WSTRB;
   logic M_WVALID, M_WREADY;
   logic [1:0] M_BRESP;
   logic M_BVALID, M_BREADY;
   logic [C_ADDR_WIDTH-1:0] M_ARADDR;
   logic M_ARVALID, M_ARREADY;
   logic [31:0] M_RDATA;
   logic [1:0] M_RRESP;
   logic M_RVALID, M_RREADY;
   modport master (
      output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY, M_ARADDR, M_ARVALID, M_RREADY,
      input M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
   );
   modport slave (
      input M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY, M_ARADDR, M_ARVALID, M_RREADY,
      output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
   );
endinterface

// File: rtl/ntt_axil_xact.sv
// ntt_axil_xact: single-outstanding AXI4-Lite write-or-read engine; ack/rdata/resp are valid in the B or R handshake cycle.
module ntt_axil_xact
   import ntt_axil_pkg::*;
#(
   parameter int C_ADDR_WIDTH = 32
) (
   input logic ACLK,
   input logic ARESETN,
   ntt_axil_if.master m,
   input logic req,
   input logic we,
   input logic [C_ADDR_WIDTH-1:0] addr,
   input logic [31:0] wdata,
   output logic ack,
   output logic [31:0] rdata,
   output logic [1:0] resp
);
   logic b_hs, r_hs, idle;
   assign b_hs = m.M_BVALID && m.M_BREADY;
   assign r_hs = m.M_RVALID && m.M_RREADY;
   assign ack = b_hs || r_hs;
   assign rdata = m.M_RDATA;
   assign resp = b_hs ? m.M_BRESP : m.M_RRESP;
   assign idle = !(m.M_AWVALID || m.M_WVALID || m.M_BREADY || m.M_ARVALID || m.M_RREADY);
   assign m.M_WSTRB = WSTRB_ALL;
   // A new request is taken in the completing cycle too, so back-to-back transactions have no bubble.
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         m.M_AWVALID <= 1'b0;
         m.M_WVALID <= 1'b0;
         m.M_BREADY <= 1'b0;
         m.M_ARVALID <= 1'b0;
         m.M_RREADY <= 1'b0;
         m.M_AWADDR <= '0;
         m.M_WDATA <= '0;
         m.M_ARADDR <= '0;
      end else begin
         if (m.M_AWREADY) m.M_AWVALID <= 1'b0;
         if (m.M_WREADY) m.M_WVALID <= 1'b0;
         if ((m.M_AWVALID || m.M_WVALID) && (!m.M_AWVALID || m.M_AWREADY) && (!m.M_WVALID || m.M_WREADY))
            m.M_BREADY <= 1'b1;
         if (b_hs) m.M_BREADY <= 1'b0;
         if (m.M_ARVALID && m.M_ARREADY) begin
            m.M_ARVALID <= 1'b0;
            m.M_RREADY <= 1'b1;
         end
         if (r_hs) m.M_RREADY <= 1'b0;
         if (req && (idle || ack)) begin
            if (we) begin
               m.M_AWVALID <= 1'b1;
               m.M_WVALID <= 1'b1;
               m.M_AWADDR <= addr;
               m.M_WDATA <= wdata;
            end else begin
               m.M_ARVALID <= 1'b1;
               m.M_ARADDR <= addr;
            end
         end
      end
endmodule

// File: rtl/ntt_axil_host.sv
// ntt_axil_host: programs modulus/root into the NTT accelerator, starts it, polls for completion and clears run.
module ntt_axil_host
   import ntt_axil_pkg::*;
#(
   parameter int C_ADDR_WIDTH = 32,
   parameter int C_DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
   input logic ACLK,
   input logic ARESETN,
   ntt_axil_if.master m,
   input logic start,
   input logic [31:0] p_in,
   input logic [31:0] r_in,
   output logic busy,
   output logic done,
   output logic error,
   output logic timeout,
   output logic [C_DATA_WIDTH-1:0] status
);
   state_t state, nxt;
   logic [31:0] p_q, r_q, x_wdata, x_rdata;
   logic [15:0] polls;
   logic [C_ADDR_WIDTH-1:0] x_addr;
   logic [1:0] x_resp;
   logic issued, issue, ack, bad, hit_limit;
   assign busy = state != IDLE;
   assign done = state == FINISH;
   assign bad = ack && x_resp != RESP_OKAY;
   always_comb begin
      nxt = state;
      hit_limit = 1'b0;
      case (state)
         IDLE: nxt = start ? WR_P : IDLE;
         WR_P: if (ack) nxt = bad ? WR_CLR : WR_R;
         WR_R: if (ack) nxt = bad ? WR_CLR : WR_RUN;
         WR_RUN: if (ack) nxt = bad ? WR_CLR : POLL;
         POLL: if (ack) begin
            hit_limit = !bad && !x_rdata[STAT_CPL] && (polls + 16'd1 >= POLL_LIMIT);
            nxt = (bad || x_rdata[STAT_CPL] || hit_limit) ? WR_CLR : POLL;
         end
         WR_CLR: if (ack) nxt = FINISH;
         default: nxt = IDLE;
      endcase
   end
   // The next state's transaction is requested in the same cycle the previous one completes.
   assign issue = busy && is_xact(nxt) && (ack || !issued);
   assign x_addr = C_ADDR_WIDTH'(BASE_ADDR) + C_ADDR_WIDTH'(reg_off(nxt));
   assign x_wdata = nxt == WR_P ? p_q : nxt == WR_R ? r_q : nxt == WR_RUN ? CTRL_GO : 32'h0;
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         state <= IDLE;
         issued <= 1'b0;
         p_q <= '0;
         r_q <= '0;
         polls <= '0;
         error <= 1'b0;
         timeout <= 1'b0;
         status <= '0;
      end else begin
         state <= nxt;
         issued <= issue || (issued && !ack);
         if (state == IDLE && start) begin
            p_q <= p_in;
            r_q <= r_in;
            polls <= '0;
            error <= 1'b0;
            timeout <= 1'b0;
         end
         if (ack && state == POLL) begin
            polls <= polls + 16'd1;
            status <= C_DATA_WIDTH'(x_rdata);
         end
         if (bad || hit_limit) error <= 1'b1;
         if (hit_limit) timeout <= 1'b1;
      end
   ntt_axil_xact #(.C_ADDR_WIDTH(C_ADDR_WIDTH)) u_xact (
      .ACLK(ACLK),
      .ARESETN(ARESETN),
      .m(m),
      .req(issue),
      .we(nxt != POLL),
      .addr(x_addr),
      .wdata(x_wdata),
      .ack(ack),
      .rdata(x_rdata),
      .resp(x_resp)
   );
endmodule

// File: tb/tb_ntt_axil_host.sv
// tb_ntt_axil_host: directed + randomized runs against a configurable AXI-Lite responder and a transaction-list model.
module tb_ntt_axil_host;
   localparam int LIM = 4;
   localparam logic [31:0] BASE = 32'h4000_0000;
   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} op_t;

   logic ACLK = 1'b0, ARESETN = 1'b0, start = 1'b0;
   logic [31:0] p_in = '0, r_in = '0, status;
   logic busy, done, error, timeout;
   ntt_axil_if #(.C_ADDR_WIDTH(32)) m ();

   ntt_axil_host #(.BASE_ADDR(BASE), .POLL_LIMIT(16'(LIM))) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .m(m), .start(start), .p_in(p_in), .r_in(r_in),
      .busy(busy), .done(done), .error(error), .timeout(timeout), .status(status)
   );

   always #5 ACLK = ~ACLK;

   int total = 0, bad = 0, done_cnt = 0, proto_bad = 0;
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0, cpl_at = 0;
   logic [31:0] err_waddr = '0;
   bit werr_on = 0, rerr_on = 0, run_new = 0;
   op_t log[$];

   // responder
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rd_idx;
   logic got_aw, got_w, bv, rpend, rv;
   logic [1:0] br, rr;
   logic [31:0] wa, wd, rdv, rnd, exp_status;
   assign m.M_AWREADY = m.M_AWVALID && aw_cnt >= aw_dly;
   assign m.M_WREADY = m.M_WVALID && w_cnt >= w_dly;
   assign m.M_ARREADY = m.M_ARVALID && ar_cnt >= ar_dly;
   assign m.M_BVALID = bv;
   assign m.M_BRESP = br;
   assign m.M_RVALID = rv;
   assign m.M_RDATA = rdv;
   assign m.M_RRESP = rr;
   always @(posedge ACLK) rnd <= $urandom;
   always @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rd_idx} <= '0;
         {got_aw, got_w, bv, rpend, rv} <= '0;
         br <= '0; rr <= '0; wa <= '0; wd <= '0; rdv <= '0; exp_status <= '0;
      end else begin
         if (m.M_AWVALID && m.M_AWREADY) begin got_aw <= 1; wa <= m.M_AWADDR; aw_cnt <= 0; end
         else if (m.M_AWVALID) aw_cnt <= aw_cnt + 1;
         if (m.M_WVALID && m.M_WREADY) begin got_w <= 1; wd <= m.M_WDATA; w_cnt <= 0; end
         else if (m.M_WVALID) w_cnt <= w_cnt + 1;
         if (got_aw && got_w && !bv) begin
            if (b_cnt >= b_dly) begin
               bv <= 1;
               br <= (werr_on && wa == err_waddr) ? 2'b10 : 2'b00;
               log.push_back({1'b1, wa, wd});
            end else b_cnt <= b_cnt + 1;
         end
         if (bv && m.M_BREADY) begin bv <= 0; got_aw <= 0; got_w <= 0; b_cnt <= 0; end
         if (m.M_ARVALID && m.M_ARREADY) begin
            rpend <= 1; r_cnt <= 0; ar_cnt <= 0;
            log.push_back({1'b0, m.M_ARADDR, 32'h0});
         end else if (m.M_ARVALID) ar_cnt <= ar_cnt + 1;
         if (rpend && !rv) begin
            if (r_cnt >= r_dly) begin
               rv <= 1;
               rdv <= {rnd[31:1], (rd_idx + 1 >= cpl_at) && (cpl_at != 0)};
               rr <= (rerr_on && rd_idx == 0) ? 2'b10 : 2'b00;
               rd_idx <= rd_idx + 1;
            end else r_cnt <= r_cnt + 1;
         end
         if (run_new) rd_idx <= 0;
         if (rv && m.M_RREADY) begin rv <= 0; rpend <= 0; r_cnt <= 0; exp_status <= rdv; end
      end

   always @(negedge ACLK) if (done) done_cnt++;

   // protocol monitor: stability, independent drops, one outstanding, BREADY ordering, strobes
   logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [31:0] p_awa, p_wd, p_ara;
   always @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} <= '0;
         p_awa <= '0; p_wd <= '0; p_ara <= '0;
      end else begin
         if (p_awv && !p_awr && (!m.M_AWVALID || m.M_AWADDR !== p_awa)) proto_bad <= proto_bad + 1;
         if (p_wv && !p_wr && (!m.M_WVALID || m.M_WDATA !== p_wd)) proto_bad <= proto_bad + 1;
         if (p_arv && !p_arr && (!m.M_ARVALID || m.M_ARADDR !== p_ara)) proto_bad <= proto_bad + 1;
         if ((p_awv && p_awr && m.M_AWVALID) || (p_wv && p_wr && m.M_WVALID) || (p_arv && p_arr && m.M_ARVALID))
            proto_bad <= proto_bad + 1;
         if (m.M_AWVALID && !p_awv && !(m.M_WVALID && !p_wv)) proto_bad <= proto_bad + 1;
         if (m.M_ARVALID && (m.M_AWVALID || m.M_WVALID || m.M_BREADY)) proto_bad <= proto_bad + 1;
         if (m.M_BREADY && (m.M_AWVALID || m.M_WVALID)) proto_bad <= proto_bad + 1;
         if (m.M_WVALID && m.M_WSTRB !== 4'hF) proto_bad <= proto_bad + 1;
         {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} <= {m.M_AWVALID, m.M_AWREADY, m.M_WVALID, m.M_WREADY, m.M_ARVALID, m.M_ARREADY};
         p_awa <= m.M_AWADDR; p_wd <= m.M_WDATA; p_ara <= m.M_ARADDR;
      end

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // kind: 0 none, 1 BRESP err on p write, 2 on r write, 3 on ctrl writes, 4 RRESP err on first poll
   task automatic run(input logic [31:0] p, input logic [31:0] r, input int cpl, input int kind,
                      input int a, input int w, input int b, input int ar, input int rd, input bit restart);
      op_t exp[$];
      int base, d0, n, cyc;
      bit er, to;
      @(negedge ACLK);
      cpl_at = cpl; aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = rd;
      werr_on = kind inside {1, 2, 3};
      rerr_on = kind == 4;
      err_waddr = BASE + (kind == 1 ? 32'h8 : kind == 2 ? 32'hC : 32'h4);
      base = log.size();
      d0 = done_cnt;
      run_new = 1; start = 1; p_in = p; r_in = r;
      @(negedge ACLK);
      run_new = 0; start = 0; p_in = $urandom; r_in = $urandom;
      er = 0; to = 0;
      exp.push_back({1'b1, BASE + 32'h8, p});
      er = kind == 1;
      if (!er) begin exp.push_back({1'b1, BASE + 32'hC, r}); er = kind == 2; end
      if (!er) begin exp.push_back({1'b1, BASE + 32'h4, 32'h3}); er = kind == 3; end
      if (!er) begin
         n = (cpl == 0 || cpl > LIM) ? LIM : cpl;
         if (kind == 4) begin n = 1; er = 1; end
         else if (cpl == 0 || cpl > LIM) begin to = 1; er = 1; end
         for (int i = 0; i < n; i++) exp.push_back({1'b0, BASE, 32'h0});
      end
      exp.push_back({1'b1, BASE + 32'h4, 32'h0});
      cyc = 0;
      while (!done && cyc < 2000) begin
         start = restart && cyc == 3;
         if (restart && cyc == 3) p_in = 32'hFFFF;
         @(negedge ACLK);
         cyc++;
      end
      start = 0;
      chk("done_seen", 65'(cyc < 2000), 65'd1);
      @(negedge ACLK);
      chk("busy_after", 65'(busy), 65'd0);
      chk("error", 65'(error), 65'(er));
      chk("timeout", 65'(timeout), 65'(to));
      chk("status", 65'(status), 65'(exp_status));
      repeat (3) @(negedge ACLK);
      chk("done_pulses", 65'(done_cnt - d0), 65'd1);
      chk("op_count", 65'(log.size() - base), 65'(exp.size()));
      for (int i = 0; i < exp.size() && base + i < log.size(); i++) chk("op", log[base + i], exp[i]);
      chk("protocol", 65'(proto_bad), 65'd0);
   endtask

   initial begin
      int d0, cyc, k;
      repeat (3) @(negedge ACLK);
      chk("rst_outs", 65'({busy, done, error, timeout, m.M_AWVALID, m.M_WVALID, m.M_BREADY, m.M_ARVALID, m.M_RREADY}), 65'd0);
      chk("rst_status", 65'(status), 65'd0);
      ARESETN = 1;
      run(32'h3001, 32'h11, 4, 0, 0, 0, 0, 0, 0, 0);
      chk("status_bit0", 65'(status[0]), 65'd1);
      run($urandom, $urandom, 2, 0, 0, 2, 3, 1, 2, 0);
      run($urandom, $urandom, 0, 0, 1, 0, 0, 0, 0, 0);
      run($urandom, $urandom, 1, 2, 0, 0, 0, 0, 0, 0);
      run(32'h1234, 32'h5678, 3, 0, 1, 1, 1, 1, 1, 1);
      run($urandom, $urandom, 2, 1, 0, 0, 0, 0, 0, 0);
      run($urandom, $urandom, 2, 3, 0, 1, 0, 0, 0, 0);
      run($urandom, $urandom, 1, 4, 0, 0, 0, 2, 1, 0);
      run($urandom, $urandom, 5, 0, 0, 0, 0, 0, 0, 0);
      // reset while a status read is waiting for ARREADY
      @(negedge ACLK);
      cpl_at = 0; ar_dly = 3; aw_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0; werr_on = 0; rerr_on = 0;
      run_new = 1; start = 1; p_in = $urandom; r_in = $urandom;
      @(negedge ACLK);
      run_new = 0; start = 0;
      cyc = 0;
      while (!m.M_ARVALID && cyc < 200) begin @(negedge ACLK); cyc++; end
      chk("arvalid_seen", 65'(cyc < 200), 65'd1);
      #2 ARESETN = 0;
      #1 chk("rst_mid", 65'({m.M_ARVALID, busy, done, error}), 65'd0);
      @(negedge ACLK);
      ARESETN = 1;
      d0 = done_cnt;
      repeat (20) @(negedge ACLK);
      chk("no_done_after_rst", 65'(done_cnt - d0), 65'd0);
      chk("idle_after_rst", 65'(busy), 65'd0);
      run($urandom, $urandom, 2, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         run($urandom, $urandom, $urandom_range(0, 6), k, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), bit'($urandom_range(0, 1)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
